// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel switch debouncer with edge and long-press pulses
module debounce_multi #(
  parameter int N_CH          = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int LONG_CYCLES   = 1000
) (
  input  logic            clk50m,
  input  logic            rst_n,
  input  logic            tick_en,
  input  logic [N_CH-1:0] sw,
  output logic [N_CH-1:0] sw_dbnc,
  output logic [N_CH-1:0] sw_hi,
  output logic [N_CH-1:0] sw_lo,
  output logic [N_CH-1:0] sw_long
);

  localparam int CW = $clog2(STABLE_CYCLES);
  localparam int LW = $clog2(LONG_CYCLES + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LCNT_PRE = LW'(LONG_CYCLES - 1);

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CW-1:0]          cnt;
    logic [LW-1:0]          lcnt;
    logic                   dbnc_q;
    logic                   hi_q;
    logic                   lo_q;
    logic                   long_q;

    // Shift the raw switch through the synchroniser chain.
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], sw[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // Stable-time filter: toggle the debounced level once the input has
    // disagreed with it for STABLE_CYCLES qualifying ticks; emit edge pulses.
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        cnt    <= '0;
        dbnc_q <= 1'b0;
        hi_q   <= 1'b0;
        lo_q   <= 1'b0;
      end else begin
        hi_q <= 1'b0;
        lo_q <= 1'b0;
        if (s == dbnc_q) begin
          cnt <= '0;
        end else if (tick_en) begin
          if (cnt == CNT_LAST) begin
            cnt    <= '0;
            dbnc_q <= s;
            hi_q   <= s;
            lo_q   <= ~s;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
      end
    end

    // Long-press timer: saturates so the pulse fires once per press and
    // re-arms only when the debounced level drops.
    always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
        lcnt   <= '0;
        long_q <= 1'b0;
      end else if (!dbnc_q) begin
        lcnt   <= '0;
        long_q <= 1'b0;
      end else begin
        long_q <= 1'b0;
        if (tick_en && (lcnt != LCNT_MAX)) begin
          lcnt   <= lcnt + LW'(1);
          long_q <= (lcnt == LCNT_PRE);
        end
      end
    end

    assign sw_dbnc[i] = dbnc_q;
    assign sw_hi[i]   = hi_q;
    assign sw_lo[i]   = lo_q;
    assign sw_long[i] = long_q;
  end

endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - randomized self-checking bench for debounce_multi
module tb_debounce_multi;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int ST = 16;
  localparam int LC = 50;

  logic         clk50m = 1'b0;
  logic         rst_n  = 1'b0;
  logic         tick_en = 1'b1;
  logic [N-1:0] sw = '0;
  logic [N-1:0] sw_dbnc, sw_hi, sw_lo, sw_long;

  int n_vec = 0;
  int n_err = 0;

  debounce_multi #(
    .N_CH(N), .SYNC_STAGES(SS), .STABLE_CYCLES(ST), .LONG_CYCLES(LC)
  ) dut (
    .clk50m(clk50m), .rst_n(rst_n), .tick_en(tick_en), .sw(sw),
    .sw_dbnc(sw_dbnc), .sw_hi(sw_hi), .sw_lo(sw_lo), .sw_long(sw_long)
  );

  always #10 clk50m = ~clk50m;

  // reference model: delay line of raw samples plus integer run/held counts
  bit q[N][$];
  bit m_dbnc[N];
  int run[N];
  int held[N];
  bit m_hi[N], m_lo[N], m_long[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      if (n_err <= 20)
        $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      q[i] = {};
      for (int k = 0; k < SS; k++) q[i].push_back(1'b0);
      m_dbnc[i] = 0; run[i] = 0; held[i] = 0;
      m_hi[i] = 0; m_lo[i] = 0; m_long[i] = 0;
    end
  endtask

  task automatic model_step();
    bit s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < N; i++) begin
      s = q[i][0];
      void'(q[i].pop_front());
      q[i].push_back(sw[i]);
      m_hi[i] = 0; m_lo[i] = 0; m_long[i] = 0;
      if (!m_dbnc[i]) held[i] = 0;
      else if (tick_en && held[i] < LC) begin
        held[i]++;
        if (held[i] == LC) m_long[i] = 1;
      end
      if (s == m_dbnc[i]) run[i] = 0;
      else if (tick_en) begin
        run[i]++;
        if (run[i] == ST) begin
          run[i] = 0;
          m_dbnc[i] = ~m_dbnc[i];
          m_hi[i] = m_dbnc[i];
          m_lo[i] = ~m_dbnc[i];
        end
      end
    end
  endtask

  function automatic logic [N-1:0] pack(input bit v[N]);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = v[i];
    return r;
  endfunction

  // one clock: model advances on the edge, outputs compared on the falling edge
  task automatic cycle();
    @(posedge clk50m);
    model_step();
    @(negedge clk50m);
    chk("sw_dbnc", 32'(sw_dbnc), 32'(pack(m_dbnc)));
    chk("sw_hi",   32'(sw_hi),   32'(pack(m_hi)));
    chk("sw_lo",   32'(sw_lo),   32'(pack(m_lo)));
    chk("sw_long", 32'(sw_long), 32'(pack(m_long)));
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_clr", 32'({sw_dbnc, sw_hi, sw_lo, sw_long}), 32'd0);
  endtask

  int hold_left[N];
  int rise_edge, hi_cnt, long_cnt, hi_at, long_at;
  int glitch[6] = '{5, 1, 3, 5, 2, 19};

  initial begin
    model_reset();
    sw = '1;
    @(negedge clk50m);
    for (int k = 0; k < 5; k++) cycle();

    // release with all switches held: level must appear on edge SS+ST
    rst_n = 1'b1;
    rise_edge = 0; hi_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      if (sw_dbnc[0] && rise_edge == 0) rise_edge = k;
      if (sw_hi[0]) hi_cnt++;
    end
    chk("release_latency", 32'(rise_edge), 32'(SS + ST));
    chk("release_hi_width", 32'(hi_cnt), 32'd1);

    // glitch train on channel 0 starting from a settled low level
    sw = '0;
    for (int k = 0; k < 40; k++) cycle();
    hi_cnt = 0;
    for (int g = 0; g < 6; g++) begin
      sw[0] = (g % 2 == 0);
      for (int k = 0; k < glitch[g]; k++) begin
        cycle();
        if (sw_hi[0] || sw_dbnc[0]) hi_cnt++;
      end
    end
    chk("glitch_reject", 32'(hi_cnt), 32'd0);

    // long press on channel 2: exactly one sw_long, LC clocks after sw_hi
    for (int p = 0; p < 2; p++) begin
      sw = '0;
      for (int k = 0; k < 30; k++) cycle();
      sw[2] = 1'b1;
      long_cnt = 0; hi_at = -1; long_at = -1;
      for (int k = 0; k < 200; k++) begin
        cycle();
        if (sw_hi[2]) hi_at = k;
        if (sw_long[2]) begin long_cnt++; long_at = k; end
      end
      chk("long_count", 32'(long_cnt), 32'd1);
      chk("long_delay", 32'(long_at - hi_at), 32'(LC));
    end
    sw = '0;
    for (int k = 0; k < 30; k++) cycle();

    // randomized phases: mode 0 short holds/ticks on, 1 short holds/1-in-4 ticks, 2 long holds
    for (int i = 0; i < N; i++) hold_left[i] = 1;
    for (int ph = 0; ph < 6; ph++) begin
      for (int c = 0; c < 2500; c++) begin
        for (int i = 0; i < N; i++) begin
          hold_left[i]--;
          if (hold_left[i] <= 0) begin
            sw[i] = ~sw[i];
            hold_left[i] = (ph % 3 == 2) ? int'($urandom_range(30, 120))
                         : (ph % 3 == 1) ? int'($urandom_range(1, 90))
                         : int'($urandom_range(1, 24));
          end
        end
        if ($urandom_range(0, 9) == 0) sw = ~sw;
        tick_en = (ph % 3 == 1) ? (c % 4 == 0) : 1'b1;
        if ($urandom_range(0, 799) == 0) begin
          async_reset();
          for (int k = 0; k < 2; k++) cycle();
          rst_n = 1'b1;
        end
        cycle();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
